// File: rtl/vga_plot_arbiter.sv
// Round-robin pixel-write arbiter for the VGA adapter plot port, with a
// built-in full-frame raster fill engine that takes priority over all clients.
module vga_plot_arbiter #(
  parameter int unsigned NUM_CLIENTS  = 4,
  parameter int unsigned X_WIDTH      = 8,
  parameter int unsigned Y_WIDTH      = 7,
  parameter int unsigned COLOUR_WIDTH = 18,
  parameter int unsigned X_MAX        = 159,
  parameter int unsigned Y_MAX        = 119
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_CLIENTS-1:0]               req_valid,
  output logic [NUM_CLIENTS-1:0]               req_ready,
  input  logic [NUM_CLIENTS*X_WIDTH-1:0]       req_x,
  input  logic [NUM_CLIENTS*Y_WIDTH-1:0]       req_y,
  input  logic [NUM_CLIENTS*COLOUR_WIDTH-1:0]  req_colour,
  input  logic                                 fill_start,
  input  logic [COLOUR_WIDTH-1:0]              fill_colour,
  output logic                                 fill_busy,
  output logic                                 fill_done,
  output logic [X_WIDTH-1:0]                   vga_x,
  output logic [Y_WIDTH-1:0]                   vga_y,
  output logic [COLOUR_WIDTH-1:0]              vga_colour,
  output logic                                 vga_write
);

  localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         last;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_found;
  logic [X_WIDTH-1:0]       fx;
  logic [Y_WIDTH-1:0]       fy;
  logic [COLOUR_WIDTH-1:0]  fill_col;
  logic [X_WIDTH-1:0]       sel_x;
  logic [Y_WIDTH-1:0]       sel_y;
  logic [COLOUR_WIDTH-1:0]  sel_colour;

  // First valid client searching upward from the one after the last winner.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      idx = (32'(last) + k) % NUM_CLIENTS;
      if (!grant_found && req_valid[IDX_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  // Unpack the granted client's pixel.
  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_x      = req_x[i*X_WIDTH +: X_WIDTH];
        sel_y      = req_y[i*Y_WIDTH +: Y_WIDTH];
        sel_colour = req_colour[i*COLOUR_WIDTH +: COLOUR_WIDTH];
      end
    end
  end

  // A fill request steals the cycle, so no client is acknowledged alongside it.
  always_comb begin
    req_ready = '0;
    if (!reset && state == IDLE && grant_found && !fill_start)
      req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last       <= IDX_W'(NUM_CLIENTS - 1);
      fx         <= '0;
      fy         <= '0;
      fill_col   <= '0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_write  <= 1'b0;
    end else begin
      vga_write <= 1'b0;
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            fill_col  <= fill_colour;
            fx        <= '0;
            fy        <= '0;
            fill_busy <= 1'b1;
            state     <= FILL;
          end else if (grant_found) begin
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
            vga_write  <= 1'b1;
            last       <= grant_idx;
          end
        end
        FILL: begin
          vga_x      <= fx;
          vga_y      <= fy;
          vga_colour <= fill_col;
          vga_write  <= 1'b1;
          // Raster scan; leaving on the last pixel lets fill_done line up with it.
          if (fx == X_WIDTH'(X_MAX)) begin
            fx <= '0;
            if (fy == Y_WIDTH'(Y_MAX)) begin
              fy        <= '0;
              fill_busy <= 1'b0;
              fill_done <= 1'b1;
              state     <= IDLE;
            end else begin
              fy <= fy + Y_WIDTH'(1);
            end
          end else begin
            fx <= fx + X_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
